process_sequencer: RTL and testbench

- Launch-and-supervise sequencer placed between the start push-button and the processor array.
- Generalises the top-level start-button debounce/reset logic into a reusable block with:
  - parametrised debounce and reset-pulse lengths,
  - N processor cores, each reporting completion,
  - a run-cycle counter for performance measurement.
- Drives the processors' active-high synchronous reset and begin strobe, and supplies a 2-bit status code to the LED state controller.

---
 rtl/process_sequencer_if.sv | 22 ++
 rtl/process_sequencer.sv | 123 ++++++++++++
 tb/tb_process_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/process_sequencer_if.sv
// process_sequencer_if: start/completion inputs and supervision outputs of the process sequencer
interface process_sequencer_if #(
  parameter int NUM_CORES = 1,
  parameter int CNT_W     = 24
);
  logic                 start_process;
  logic [NUM_CORES-1:0] end_process;
  logic                 core_rst;
  logic                 begin_process;
  logic [1:0]           status;
  logic [NUM_CORES-1:0] done_mask;
  logic [CNT_W-1:0]     run_cycles;
  logic                 timeout;
  modport master (
    output start_process, end_process,
    input  core_rst, begin_process, status, done_mask, run_cycles, timeout
  );
  modport slave (
    input  start_process, end_process,
    output core_rst, begin_process, status, done_mask, run_cycles, timeout
  );
endinterface

// File: rtl/process_sequencer.sv
// process_sequencer: debounced launch, core reset pulse, run supervision and cycle count; watchdog under PROCESS_TIMEOUT_EN
module process_sequencer #(
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int RST_CYCLES      = 4,
  parameter int NUM_CORES       = 1,
  parameter int CNT_W           = 24,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input logic               clock,
  input logic               rst_n,
  process_sequencer_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);
  if (DEBOUNCE_CYCLES < 1 || RST_CYCLES < 1 || NUM_CORES < 1 || NUM_CORES > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("process_sequencer: parameter out of range");
  end
  typedef enum logic [2:0] {IDLE, DEBOUNCE, RESET, RUN, DONE} state_t;
  state_t               state_q, state_d;
  logic [1:0]           sync_q, vld_q;
  logic                 arm_q;
  logic [DW-1:0]        deb_q, deb_d;
  logic [RW-1:0]        rcnt_q, rcnt_d;
  logic [CNT_W-1:0]     run_q, run_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic                 core_rst_q, begin_q;
  logic [1:0]           status_q;
  logic                 start_s, all_done;
`ifdef PROCESS_TIMEOUT_EN
  logic                 to_q, to_d;
`endif
  assign start_s  = sync_q[1];
  assign all_done = &(mask_q | bus.end_process);
  // next state and counters; releasing the switch aborts from any active state
  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    rcnt_d  = rcnt_q;
    run_d   = run_q;
    mask_d  = mask_q;
`ifdef PROCESS_TIMEOUT_EN
    to_d    = to_q;
`endif
    case (state_q)
      IDLE: if (start_s && arm_q) begin
        state_d = DEBOUNCE;
        deb_d   = DW'(1);
      end
      DEBOUNCE: if (!start_s) begin
        state_d = IDLE;
        deb_d   = '0;
      end else if (deb_q == DW'(DEBOUNCE_CYCLES)) begin
        state_d = RESET;
        rcnt_d  = '0;
        mask_d  = '0;
        run_d   = '0;
      end else deb_d = deb_q + 1'b1;
      RESET: if (!start_s) state_d = IDLE;
        else if (rcnt_q == RW'(RST_CYCLES - 1)) state_d = RUN;
        else rcnt_d = rcnt_q + 1'b1;
      RUN: if (!start_s) state_d = IDLE;
        else begin
          mask_d = mask_q | bus.end_process;
          run_d  = &run_q ? run_q : run_q + 1'b1;
          if (all_done) state_d = DONE;
`ifdef PROCESS_TIMEOUT_EN
          else if (run_q >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = DONE;
            to_d    = 1'b1;
          end
`endif
        end
      DONE: if (!start_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef PROCESS_TIMEOUT_EN
    if (state_d == IDLE) to_d = 1'b0;
`endif
  end
  // state, synchroniser and registered outputs; arm_q blocks relaunch until the switch is really seen low after reset
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      vld_q      <= '0;
      arm_q      <= 1'b0;
      deb_q      <= '0;
      rcnt_q     <= '0;
      run_q      <= '0;
      mask_q     <= '0;
      core_rst_q <= 1'b0;
      begin_q    <= 1'b0;
      status_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], bus.start_process};
      vld_q      <= {vld_q[0], 1'b1};
      arm_q      <= arm_q | (vld_q[1] & ~start_s);
      deb_q      <= deb_d;
      rcnt_q     <= rcnt_d;
      run_q      <= run_d;
      mask_q     <= mask_d;
      core_rst_q <= state_d == RESET;
      begin_q    <= state_d == RUN;
      status_q   <= state_d == IDLE ? 2'd0 : state_d == RUN ? 2'd2 : state_d == DONE ? 2'd3 : 2'd1;
    end
  end
`ifdef PROCESS_TIMEOUT_EN
  // sticky watchdog flag, cleared on return to IDLE
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) to_q <= 1'b0;
    else to_q <= to_d;
  end
  assign bus.timeout = to_q;
`else
  assign bus.timeout = 1'b0;
`endif
  assign bus.core_rst      = core_rst_q;
  assign bus.begin_process = begin_q;
  assign bus.status        = status_q;
  assign bus.done_mask     = mask_q;
  assign bus.run_cycles    = run_q;
endmodule

// File: tb/tb_process_sequencer.sv
// tb_process_sequencer: directed and random checks of process_sequencer against a cycle model
module tb_process_sequencer;
  localparam int DEB = 10, RSTC = 4, NC = 2, CW = 24, TMO = 50;
  localparam int RUN_MAX = 2 ** CW - 1;
  localparam int P_IDLE = 0, P_DEB = 1, P_RST = 2, P_RUN = 3, P_DONE = 4;
`ifdef PROCESS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clock = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0, errors = 0, cyc = 0;
  process_sequencer_if #(.NUM_CORES(NC), .CNT_W(CW)) bus();
  process_sequencer #(.DEBOUNCE_CYCLES(DEB), .RST_CYCLES(RSTC), .NUM_CORES(NC), .CNT_W(CW), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clock = ~clock;
  logic [30:0] obs;
  assign obs = {bus.core_rst, bus.begin_process, bus.status, bus.done_mask, bus.run_cycles, bus.timeout};
  int m_phase, m_deb, m_rst, m_run, m_vld;
  logic m_s1, m_s2, m_arm, m_to;
  logic [NC-1:0] m_mask;
  task automatic model_reset();
    m_phase = P_IDLE; m_deb = 0; m_rst = 0; m_run = 0; m_vld = 0;
    m_s1 = 0; m_s2 = 0; m_arm = 0; m_to = 0; m_mask = '0;
  endtask
  function automatic logic [30:0] exp_vec();
    logic [1:0] st;
    st = m_phase == P_IDLE ? 2'd0 : m_phase == P_RUN ? 2'd2 : m_phase == P_DONE ? 2'd3 : 2'd1;
    return {m_phase == P_RST, m_phase == P_RUN, st, m_mask, CW'(m_run), m_to};
  endfunction
  task automatic tick();
    int np;
    logic s;
    @(posedge clock);
    s = m_s2;
    np = m_phase;
    case (m_phase)
      P_IDLE: if (s && m_arm) begin np = P_DEB; m_deb = 1; end
      P_DEB: if (!s) np = P_IDLE;
        else if (m_deb == DEB) begin np = P_RST; m_rst = 0; m_mask = '0; m_run = 0; end
        else m_deb++;
      P_RST: if (!s) np = P_IDLE;
        else begin m_rst++; if (m_rst == RSTC) np = P_RUN; end
      P_RUN: if (!s) np = P_IDLE;
        else begin
          m_mask |= bus.end_process;
          if (m_run < RUN_MAX) m_run++;
          if (m_mask == '1) np = P_DONE;
          else if (TO_EN && m_run >= TMO) begin np = P_DONE; m_to = 1; end
        end
      P_DONE: if (!s) np = P_IDLE;
      default: np = P_IDLE;
    endcase
    if (np == P_IDLE) m_to = 0;
    if (m_vld >= 2 && !s) m_arm = 1;
    m_s2 = m_s1;
    m_s1 = bus.start_process;
    if (m_vld < 2) m_vld++;
    m_phase = np;
    cyc++;
    #1;
  endtask
  task automatic test_reset();
    rst_n = 0;
    #1;
    checks++; if (obs !== '0) begin errors++; $display("FAIL reset_async got=%h exp=0", obs); end
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    rst_n = 1;
    repeat (5) begin
      tick();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
  endtask
  task automatic test_launch();
    bus.start_process = 1;
    for (int e = 0; e <= 18; e++) begin
      tick();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL launch_model edge=%0d got=%h exp=%h", e, obs, exp_vec()); end
      checks++; if (bus.core_rst !== (e >= 12 && e <= 15)) begin errors++; $display("FAIL launch_core_rst edge=%0d got=%b exp=%b", e, bus.core_rst, (e >= 12 && e <= 15)); end
      checks++; if (bus.begin_process !== (e >= 16)) begin errors++; $display("FAIL launch_begin edge=%0d got=%b exp=%b", e, bus.begin_process, (e >= 16)); end
    end
  endtask
  task automatic test_multicore();
    logic [NC-1:0] p;
    for (int n = 0; n < 100; n++) begin
      p = (m_phase == P_RUN && m_run == 20) ? 2'b01 : (m_phase == P_RUN && m_run == 35) ? 2'b10 : 2'b00;
      bus.end_process = p;
      tick();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL multicore_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
      if (p == 2'b01) begin
        checks++; if (bus.done_mask !== 2'b01) begin errors++; $display("FAIL multicore_mask01 got=%b exp=01", bus.done_mask); end
      end
      if (p == 2'b10) begin
        checks++; if (bus.status !== 2'd3) begin errors++; $display("FAIL multicore_status got=%0d exp=3", bus.status); end
        checks++; if (bus.run_cycles !== CW'(36)) begin errors++; $display("FAIL multicore_run got=%0d exp=36", bus.run_cycles); end
        checks++; if (bus.done_mask !== 2'b11) begin errors++; $display("FAIL multicore_mask11 got=%b exp=11", bus.done_mask); end
        checks++; if (bus.begin_process !== 1'b0) begin errors++; $display("FAIL multicore_begin got=%b exp=0", bus.begin_process); end
        break;
      end
    end
    bus.end_process = '0;
    bus.start_process = 0;
    repeat (4) begin
      tick();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL multicore_release cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    checks++; if (bus.status !== 2'd0) begin errors++; $display("FAIL multicore_idle got=%0d exp=0", bus.status); end
  endtask
  task automatic test_bounce();
    for (int e = 0; e <= 20; e++) begin
      bus.start_process = (e != 6);
      tick();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL bounce_model edge=%0d got=%h exp=%h", e, obs, exp_vec()); end
      checks++; if (bus.core_rst !== (e >= 19)) begin errors++; $display("FAIL bounce_core_rst edge=%0d got=%b exp=%b", e, bus.core_rst, (e >= 19)); end
    end
    bus.start_process = 0;
    repeat (5) begin
      tick();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL bounce_release cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
  endtask
  task automatic test_abort();
    int n;
    bus.start_process = 1;
    n = 0;
    while (m_phase != P_RST && n < 30) begin
      tick(); n++;
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL abort_rst_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    checks++; if (bus.core_rst !== 1'b1) begin errors++; $display("FAIL abort_reached_reset got=%b exp=1", bus.core_rst); end
    bus.start_process = 0;
    repeat (3) begin
      tick();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL abort_rst_release cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    checks++; if (bus.status !== 2'd0 || bus.core_rst !== 1'b0) begin errors++; $display("FAIL abort_rst_idle status=%0d core_rst=%b exp 0/0", bus.status, bus.core_rst); end
    bus.start_process = 1;
    n = 0;
    while (!(m_phase == P_RUN && m_run == 3) && n < 40) begin
      tick(); n++;
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL abort_run_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    bus.start_process = 0;
    repeat (3) begin
      tick();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL abort_run_release cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    checks++; if (bus.status !== 2'd0) begin errors++; $display("FAIL abort_run_status got=%0d exp=0", bus.status); end
    checks++; if (bus.run_cycles !== CW'(5)) begin errors++; $display("FAIL abort_run_cycles got=%0d exp=5", bus.run_cycles); end
    checks++; if (bus.begin_process !== 1'b0 || bus.core_rst !== 1'b0) begin errors++; $display("FAIL abort_run_outputs begin=%b core_rst=%b exp 0/0", bus.begin_process, bus.core_rst); end
  endtask
  task automatic test_async_reset();
    int n;
    bus.start_process = 1;
    n = 0;
    while (!(m_phase == P_RUN && m_run >= 8) && n < 60) begin
      tick(); n++;
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL areset_launch cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    checks++; if (bus.begin_process !== 1'b1) begin errors++; $display("FAIL areset_running got=%b exp=1", bus.begin_process); end
    #2 rst_n = 0;
    #1;
    checks++; if (obs !== '0) begin errors++; $display("FAIL areset_outputs got=%h exp=0", obs); end
    model_reset();
    @(posedge clock);
    @(negedge clock);
    rst_n = 1;
    repeat (30) begin
      tick();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL areset_hold_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
      checks++; if (bus.status !== 2'd0) begin errors++; $display("FAIL areset_no_relaunch cyc=%0d got=%0d exp=0", cyc, bus.status); end
    end
    bus.start_process = 0;
    repeat (5) tick();
    bus.start_process = 1;
    n = 0;
    while (m_phase != P_RUN && n < 40) begin
      tick(); n++;
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL areset_relaunch_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    checks++; if (bus.begin_process !== 1'b1) begin errors++; $display("FAIL areset_relaunch got=%b exp=1", bus.begin_process); end
    bus.start_process = 0;
    repeat (5) tick();
  endtask
  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) bus.start_process = ~bus.start_process;
      bus.end_process = {$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0};
      tick();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    bus.end_process = '0;
  endtask
`ifdef PROCESS_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bus.start_process = 0;
    bus.end_process = '0;
    repeat (5) tick();
    bus.start_process = 1;
    n = 0;
    while (m_phase != P_DONE && n < 120) begin
      tick(); n++;
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL timeout_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag got=%b exp=1", bus.timeout); end
    checks++; if (bus.status !== 2'd3) begin errors++; $display("FAIL timeout_status got=%0d exp=3", bus.status); end
    checks++; if (bus.run_cycles !== CW'(TMO)) begin errors++; $display("FAIL timeout_run got=%0d exp=%0d", bus.run_cycles, TMO); end
    bus.start_process = 0;
    repeat (4) begin
      tick();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL timeout_release cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear got=%b exp=0", bus.timeout); end
  endtask
`endif
  initial begin
    bus.start_process = 0;
    bus.end_process = '0;
    model_reset();
    #2;
    test_reset();
    test_launch();
    test_multicore();
    test_bounce();
    test_abort();
    test_async_reset();
    test_random();
`ifdef PROCESS_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end
endmodule
